// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with per-tenure beat quota, HLOCK and address/data muxing
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_BEATS = 8,
  parameter int DEF_MASTER = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NUM_MASTERS-1:0]    HBUSREQ,
  input  logic [NUM_MASTERS-1:0]    HLOCK,
  input  logic [32*NUM_MASTERS-1:0] M_HADDR,
  input  logic [2*NUM_MASTERS-1:0]  M_HTRANS,
  input  logic [NUM_MASTERS-1:0]    M_HWRITE,
  input  logic [32*NUM_MASTERS-1:0] M_HWDATA,
  input  logic                     HREADY,
  output logic [NUM_MASTERS-1:0]    HGRANT,
  output logic [2:0]               HMASTER,
  output logic [2:0]               HMASTER_D,
  output logic [31:0]              HADDR,
  output logic [1:0]               HTRANS,
  output logic                     HWRITE,
  output logic [31:0]              HWDATA
);
  typedef enum logic {PARK, OWN} state_t;
  localparam logic [2:0] DEF = 3'(DEF_MASTER);
  localparam logic [7:0] MAXB = 8'(MAX_BEATS);
  localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  state_t state, state_n;
  logic [2:0] ptr, ptr_n, master_n, winner;
  logic [7:0] cnt, cnt_n;
  logic [NUM_MASTERS-1:0] oh, rot;
  logic beat, quota, rearb;
  assign oh = ONE << HMASTER;
  assign HADDR = 32'(M_HADDR >> (32 * HMASTER));
  assign HTRANS = state == OWN ? 2'(M_HTRANS >> (2 * HMASTER)) : 2'b00;
  assign HWRITE = |(M_HWRITE & oh);
  assign HWDATA = 32'(M_HWDATA >> (32 * HMASTER_D));
  always_comb begin
    rot = NUM_MASTERS'({HBUSREQ, HBUSREQ} >> (ptr + 3'd1));
    winner = DEF;
    for (int j = NUM_MASTERS - 1; j >= 0; j--)
      if (rot[j]) winner = 3'((int'(ptr) + 1 + j) % NUM_MASTERS);
    beat = state == OWN & HREADY & HTRANS[1];
    quota = (cnt == MAXB) | (beat & (cnt == MAXB - 8'd1));
    rearb = HREADY & (state == PARK ? |HBUSREQ
                      : ~|(HLOCK & oh) & (~|(HBUSREQ & oh) | (quota & |(HBUSREQ & ~oh))));
    state_n = rearb ? (|rot ? OWN : PARK) : state;
    master_n = rearb ? (|rot ? winner : DEF) : HMASTER;
    ptr_n = rearb & |rot ? winner : ptr;
    cnt_n = rearb ? 8'd0 : (beat & (cnt != MAXB) ? cnt + 8'd1 : cnt);
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= PARK;
      HMASTER <= DEF;
      HMASTER_D <= DEF;
      HGRANT <= ONE << DEF;
      ptr <= DEF;
      cnt <= 8'd0;
    end else begin
      state <= state_n;
      HMASTER <= master_n;
      HGRANT <= ONE << master_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      if (HREADY) HMASTER_D <= HMASTER;
    end
  end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: scoreboard bench for ahb_bus_arbiter against a behavioural arbitration model
module tb_ahb_bus_arbiter;
  localparam int N = 4;
  localparam int MAXB = 8;
  localparam int DEF = 0;
  logic HCLK = 1'b0;
  logic HRESET;
  logic [N-1:0] HBUSREQ, HLOCK, M_HWRITE, HGRANT;
  logic [32*N-1:0] M_HADDR, M_HWDATA;
  logic [2*N-1:0] M_HTRANS;
  logic HREADY, HWRITE;
  logic [2:0] HMASTER, HMASTER_D;
  logic [31:0] HADDR, HWDATA;
  logic [1:0] HTRANS;
  ahb_bus_arbiter #(.NUM_MASTERS(N), .MAX_BEATS(MAXB), .DEF_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HWDATA(M_HWDATA),
    .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTER_D(HMASTER_D),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA)
  );
  always #5 HCLK = ~HCLK;
  typedef struct packed {
    logic [N-1:0] grant;
    logic [2:0] master;
    logic [2:0] master_d;
    logic [31:0] haddr;
    logic [1:0] htrans;
    logic hwrite;
    logic [31:0] hwdata;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  bit m_park = 1;
  int m_master = DEF, m_master_d = DEF, m_ptr = DEF, m_cnt = 0;
  logic [31:0] mem [256];
  logic wp;
  logic [7:0] wa;
  always @(posedge HCLK)
    if (HRESET) wp <= 1'b0;
    else if (HREADY) begin
      if (wp) mem[wa] <= HWDATA;
      wp <= HTRANS[1] & HWRITE;
      wa <= HADDR[9:2];
    end
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic exp_t model_out();
    exp_t e;
    e.grant = N'(1 << m_master);
    e.master = 3'(m_master);
    e.master_d = 3'(m_master_d);
    e.haddr = M_HADDR[32*m_master +: 32];
    e.htrans = m_park ? 2'b00 : M_HTRANS[2*m_master +: 2];
    e.hwrite = M_HWRITE[m_master];
    e.hwdata = M_HWDATA[32*m_master_d +: 32];
    return e;
  endfunction
  task automatic model_step();
    bit beat, go, others;
    int after, w;
    if (HRESET) begin
      m_park = 1; m_master = DEF; m_master_d = DEF; m_ptr = DEF; m_cnt = 0;
      return;
    end
    if (!HREADY) return;
    beat = !m_park && M_HTRANS[2*m_master+1];
    after = beat ? ((m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1) : m_cnt;
    others = 0;
    for (int i = 0; i < N; i++) if (i != m_master && HBUSREQ[i]) others = 1;
    go = m_park ? (HBUSREQ != 0)
                : (!HLOCK[m_master] && (!HBUSREQ[m_master] || (after == MAXB && others)));
    m_master_d = m_master;
    if (!go) begin
      m_cnt = after;
      return;
    end
    w = -1;
    for (int k = 1; k <= N; k++) if (w < 0 && HBUSREQ[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    m_cnt = 0;
    if (w < 0) begin
      m_park = 1; m_master = DEF;
    end else begin
      m_park = 0; m_master = w; m_ptr = w;
    end
  endtask
  task automatic cycle();
    sb.push_back(model_out());
    model_step();
    @(posedge HCLK);
    #2;
  endtask
  always @(negedge HCLK)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_hgrant", 32'(HGRANT), 32'(e.grant));
      chk("sb_hmaster", 32'(HMASTER), 32'(e.master));
      chk("sb_hmaster_d", 32'(HMASTER_D), 32'(e.master_d));
      chk("sb_haddr", HADDR, e.haddr);
      chk("sb_htrans", 32'(HTRANS), 32'(e.htrans));
      chk("sb_hwrite", 32'(HWRITE), 32'(e.hwrite));
      chk("sb_hwdata", HWDATA, e.hwdata);
    end
  task automatic do_reset();
    HRESET = 1; HBUSREQ = '0; HLOCK = '0; HREADY = 1; M_HTRANS = '0;
    cycle();
    cycle();
    HRESET = 0;
  endtask
  initial begin
    int beats, nrec;
    int order[5];
    int last;
    HRESET = 1; HBUSREQ = '0; HLOCK = '0; HREADY = 1;
    M_HADDR = '0; M_HTRANS = '0; M_HWRITE = '0; M_HWDATA = '0;
    @(posedge HCLK);
    #2;
    do_reset();
    chk("reset_hgrant", 32'(HGRANT), 32'h1);
    chk("reset_hmaster", 32'(HMASTER), 32'h0);
    chk("reset_htrans", 32'(HTRANS), 32'h0);
    HBUSREQ = 4'b0100;
    cycle();
    chk("single_grant", 32'(HGRANT), 32'h4);
    M_HADDR[64 +: 32] = 32'h10; M_HTRANS[4 +: 2] = 2'b10; M_HWRITE[2] = 1'b1;
    cycle();
    M_HTRANS[4 +: 2] = 2'b00; M_HWDATA[64 +: 32] = 32'hA5A5A5A5; HBUSREQ = '0;
    cycle();
    chk("single_mem4", mem[4], 32'hA5A5A5A5);
    do_reset();
    HBUSREQ = 4'b1111; M_HTRANS = 8'hFF;
    nrec = 0; last = -1;
    for (int i = 0; i < 80 && nrec < 5; i++) begin
      cycle();
      if (int'(HMASTER) != last) begin
        last = int'(HMASTER);
        order[nrec] = last;
        nrec++;
      end
    end
    chk("rr_count", 32'(nrec), 32'd5);
    chk("rr_order0", 32'(order[0]), 32'd1);
    chk("rr_order1", 32'(order[1]), 32'd2);
    chk("rr_order2", 32'(order[2]), 32'd3);
    chk("rr_order3", 32'(order[3]), 32'd0);
    chk("rr_order4", 32'(order[4]), 32'd1);
    do_reset();
    HBUSREQ = 4'b1010; M_HTRANS = 8'hFF;
    cycle();
    chk("quota_first", 32'(HGRANT), 32'h2);
    beats = 0;
    for (int i = 0; i < 40 && HGRANT != 4'b1000; i++) begin
      if (HGRANT == 4'b0010) beats++;
      cycle();
    end
    chk("quota_switch", 32'(HGRANT), 32'h8);
    chk("quota_beats", 32'(beats), 32'd8);
    chk("quota_hmd_hold", 32'(HMASTER_D), 32'd1);
    cycle();
    chk("quota_hmd_next", 32'(HMASTER_D), 32'd3);
    do_reset();
    HBUSREQ = 4'b0011; HLOCK = 4'b0010; M_HTRANS = 8'hFF; M_HWDATA[32 +: 32] = 32'h11112222;
    for (int i = 0; i < 21; i++) cycle();
    chk("lock_hold", 32'(HGRANT), 32'h2);
    HREADY = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wait_grant", 32'(HGRANT), 32'h2);
      chk("wait_hmaster", 32'(HMASTER), 32'd1);
      chk("wait_hwdata", HWDATA, 32'h11112222);
    end
    HLOCK = '0; HREADY = 1;
    cycle();
    chk("lock_release", 32'(HGRANT), 32'h1);
    do_reset();
    HBUSREQ = 4'b0100; M_HTRANS = '0;
    cycle();
    M_HTRANS[4 +: 2] = 2'b10;
    cycle();
    M_HTRANS[4 +: 2] = 2'b11;
    cycle();
    HRESET = 1;
    cycle();
    HRESET = 0;
    chk("rst_mid_grant", 32'(HGRANT), 32'h1);
    chk("rst_mid_hmaster", 32'(HMASTER), 32'd0);
    chk("rst_mid_htrans", 32'(HTRANS), 32'd0);
    for (int i = 0; i < 1500; i++) begin
      HRESET = ($urandom_range(99) == 0);
      HBUSREQ = N'($urandom);
      for (int b = 0; b < N; b++) HLOCK[b] = ($urandom_range(7) == 0);
      M_HADDR = {$urandom, $urandom, $urandom, $urandom};
      M_HWDATA = {$urandom, $urandom, $urandom, $urandom};
      M_HTRANS = 8'($urandom);
      M_HWRITE = N'($urandom);
      HREADY = ($urandom_range(4) != 0);
      cycle();
    end
    @(negedge HCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
